// File: rtl/burst_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_rr_arbiter_if
// Description : Request/grant bundle between NUM_REQS input FIFOs and the
//               burst round-robin arbiter that shares one downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface burst_rr_arbiter_if #(
    parameter int NUM_REQS = 4,
    parameter int BURST    = 4,
    parameter int IDXWID   = $clog2(NUM_REQS),
    parameter int CNTWID   = $clog2(BURST) + 1
);
    logic                blk;
    logic [NUM_REQS-1:0] reqs;
    logic [NUM_REQS-1:0] gnt;
    logic                gnt_vld;
    logic [IDXWID-1:0]   owner;
    logic [CNTWID-1:0]   burst_cnt;
    logic                busy;

    // Arbiter side: consumes requests and stall, produces grants and status.
    modport master (
        input  blk,
        input  reqs,
        output gnt,
        output gnt_vld,
        output owner,
        output burst_cnt,
        output busy
    );

    // FIFO/consumer side: presents requests and stall, observes grants.
    modport slave (
        output blk,
        output reqs,
        input  gnt,
        input  gnt_vld,
        input  owner,
        input  burst_cnt,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/burst_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : burst_rr_arbiter
// Description : Work-conserving round-robin arbiter. The current owner keeps
//               the grant for up to BURST consecutive cycles, then ownership
//               rotates to the next requester after it. Grants are one-hot,
//               combinational, and drive FIFO pops directly.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_rr_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int BURST    = 4,
    parameter int IDXWID   = $clog2(NUM_REQS),
    parameter int CNTWID   = $clog2(BURST) + 1
) (
    input  logic                clk,
    input  logic                rst,
    burst_rr_arbiter_if.master  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic [CNTWID-1:0] C_BURST = CNTWID'(BURST);
    localparam logic [CNTWID-1:0] C_ONE   = CNTWID'(1);
    localparam logic [IDXWID-1:0] C_LAST  = IDXWID'(NUM_REQS - 1);

    state_t              state_q;
    logic [IDXWID-1:0]   owner_q;
    logic [CNTWID-1:0]   burst_cnt_q;
    logic                busy_q;

    logic [IDXWID-1:0]   w_probe;
    logic [IDXWID-1:0]   w_search_idx;
    logic                w_continue;
    logic                w_grant_en;
    logic [IDXWID-1:0]   w_sel;
    logic [NUM_REQS-1:0] w_gnt;

    // Index reached by stepping 'step' places after 'base', wrapping at NUM_REQS.
    function automatic logic [IDXWID-1:0] wrap_idx(input logic [IDXWID-1:0] base,
                                                   input int step);
        int s;
        s = (int'(base) + step) % NUM_REQS;
        return IDXWID'(s);
    endfunction

    // Rotating search: probe from farthest (owner itself) to nearest so that
    // the last hit, i.e. the first requester after owner, wins.
    always_comb begin
        w_search_idx = owner_q;
        w_probe      = owner_q;
        for (int k = NUM_REQS; k >= 1; k--) begin
            w_probe = wrap_idx(owner_q, k);
            if (bus.reqs[w_probe]) begin
                w_search_idx = w_probe;
            end
        end
    end

    // Burst continuation vs. rotation, and the resulting one-hot grant.
    always_comb begin
        w_continue = (state_q == SERVE) && bus.reqs[owner_q] && (burst_cnt_q < C_BURST);
        w_grant_en = !rst && !bus.blk && (|bus.reqs);
        w_sel      = w_continue ? owner_q : w_search_idx;
        w_gnt      = '0;
        if (w_grant_en) begin
            w_gnt[w_sel] = 1'b1;
        end
    end

    // Owner/burst state machine; status outputs are registered alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= C_LAST;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else if (!bus.blk) begin
            if (|bus.reqs) begin
                if (w_continue) begin
                    burst_cnt_q <= burst_cnt_q + C_ONE;
                end else begin
                    owner_q     <= w_search_idx;
                    burst_cnt_q <= C_ONE;
                end
                state_q <= SERVE;
                busy_q  <= 1'b1;
            end else begin
                state_q     <= IDLE;
                burst_cnt_q <= '0;
                busy_q      <= 1'b0;
            end
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.gnt_vld   = |w_gnt;
    assign bus.owner     = owner_q;
    assign bus.burst_cnt = burst_cnt_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_rr_arbiter
// Description : Self-checking bench for burst_rr_arbiter (NUM_REQS=4, BURST=2):
//               directed scenarios plus randomized FIFO traffic against a
//               behavioural owner/streak model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_rr_arbiter;

    localparam int N  = 4;
    localparam int BR = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    burst_rr_arbiter_if #(.NUM_REQS(N), .BURST(BR), .IDXWID(2), .CNTWID(2)) bus ();

    burst_rr_arbiter #(.NUM_REQS(N), .BURST(BR), .IDXWID(2), .CNTWID(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.blk  = 1'b0;
        bus.reqs = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.blk  = 1'b0;
        bus.reqs = 4'b1111;
        tick();
        #4;
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        n_cmp++; if (bus.owner !== 2'd3) begin n_fail++; $display("FAIL reset_owner got=%0d exp=3", bus.owner); end
        n_cmp++; if (bus.burst_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", bus.burst_cnt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                  4'b0100, 4'b0100, 4'b1000, 4'b1000};
        logic [1:0] exp_c [8] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        do_reset();
        bus.reqs = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #4;
            n_cmp++; if (bus.gnt !== exp_g[i]) begin n_fail++; $display("FAIL rot_gnt[%0d] got=%b exp=%b", i, bus.gnt, exp_g[i]); end
            tick();
            n_cmp++; if (bus.burst_cnt !== exp_c[i]) begin n_fail++; $display("FAIL rot_cnt[%0d] got=%0d exp=%0d", i, bus.burst_cnt, exp_c[i]); end
        end
    endtask

    task automatic test_sole_requester();
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        do_reset();
        bus.reqs = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #4;
            n_cmp++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL sole_gnt[%0d] got=%b exp=0100", i, bus.gnt); end
            tick();
            n_cmp++; if (bus.burst_cnt !== exp_c[i]) begin n_fail++; $display("FAIL sole_cnt[%0d] got=%0d exp=%0d", i, bus.burst_cnt, exp_c[i]); end
        end
        n_cmp++; if (bus.owner !== 2'd2) begin n_fail++; $display("FAIL sole_owner got=%0d exp=2", bus.owner); end
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.reqs = 4'b0011;
        #4;
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL drop_first got=%b exp=0001", bus.gnt); end
        tick();
        bus.reqs = 4'b0010;
        #4;
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL drop_gnt got=%b exp=0010", bus.gnt); end
        tick();
        n_cmp++; if (bus.burst_cnt !== 2'd1) begin n_fail++; $display("FAIL drop_cnt got=%0d exp=1", bus.burst_cnt); end
        n_cmp++; if (bus.owner !== 2'd1) begin n_fail++; $display("FAIL drop_owner got=%0d exp=1", bus.owner); end
    endtask

    task automatic test_blk();
        do_reset();
        bus.reqs = 4'b1111;
        tick();
        bus.blk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_cmp++; if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0) begin n_fail++; $display("FAIL blk_gnt[%0d] got=%b/%b exp=0000/0", i, bus.gnt, bus.gnt_vld); end
            tick();
            n_cmp++; if (bus.owner !== 2'd0 || bus.burst_cnt !== 2'd1 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL blk_hold[%0d] got owner=%0d cnt=%0d busy=%b exp 0/1/1", i, bus.owner, bus.burst_cnt, bus.busy);
            end
        end
        bus.blk = 1'b0;
        #4;
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL blk_resume got=%b exp=0001", bus.gnt); end
        tick();
        n_cmp++; if (bus.burst_cnt !== 2'd2) begin n_fail++; $display("FAIL blk_cnt got=%0d exp=2", bus.burst_cnt); end
        #4;
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL blk_rotate got=%b exp=0010", bus.gnt); end
    endtask

    task automatic test_rst_mid_burst();
        do_reset();
        bus.reqs = 4'b0100;
        tick();
        rst      = 1'b1;
        bus.reqs = 4'b1111;
        #4;
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=0000", bus.gnt); end
        tick();
        rst = 1'b0;
        #4;
        n_cmp++; if (bus.owner !== 2'd3 || bus.burst_cnt !== 2'd0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state got owner=%0d cnt=%0d busy=%b exp 3/0/0", bus.owner, bus.burst_cnt, bus.busy);
        end
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first got=%b exp=0001", bus.gnt); end
        tick();
    endtask

    // Random push traffic into four depth-8 FIFOs; the model tracks the last
    // owner and the length of its current streak of grants.
    task automatic test_random_fifos();
        int         q [4][$];
        int         wr [4];
        int         rd [4];
        int         waitc [4];
        logic [1:0] m_owner;
        int         m_cnt;
        int         expi;
        int         v;
        logic [1:0] ix;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] eg;
        logic       b;
        for (int i = 0; i < 4; i++) begin wr[i] = 0; rd[i] = 0; waitc[i] = 0; end
        do_reset();
        m_owner = 2'd3;
        m_cnt   = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            r = '0;
            for (int i = 0; i < 4; i++) r[i] = (q[i].size() != 0);
            b = (cyc < 1000) && ($urandom_range(0, 9) == 0);
            bus.reqs = r;
            bus.blk  = b;
            #4;
            expi = -1;
            if (!b && r != 4'b0) begin
                if (m_cnt > 0 && m_cnt < BR && r[m_owner]) begin
                    expi = int'(m_owner);
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        ix = 2'((int'(m_owner) + k) % 4);
                        if (expi < 0 && r[ix]) expi = int'(ix);
                    end
                end
            end
            eg = (expi < 0) ? 4'b0000 : (4'b0001 << expi);
            g  = bus.gnt;
            n_cmp++; if (g !== eg) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, g, eg); end
            n_cmp++; if (bus.gnt_vld !== (eg != 4'b0)) begin n_fail++; $display("FAIL rnd_vld cyc=%0d got=%b", cyc, bus.gnt_vld); end
            n_cmp++; if (bus.owner !== m_owner) begin n_fail++; $display("FAIL rnd_owner cyc=%0d got=%0d exp=%0d", cyc, bus.owner, m_owner); end
            n_cmp++; if (bus.burst_cnt !== 2'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.burst_cnt, m_cnt); end
            n_cmp++; if (bus.busy !== (m_cnt != 0)) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b", cyc, bus.busy); end
            n_cmp++; if ((g & ~r) !== 4'b0) begin n_fail++; $display("FAIL rnd_empty_pop cyc=%0d gnt=%b reqs=%b", cyc, g, r); end
            if (g != 4'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (!r[i] || g[i]) begin
                        waitc[i] = 0;
                    end else begin
                        waitc[i]++;
                        n_cmp++; if (waitc[i] > (N - 1) * BR) begin n_fail++; $display("FAIL rnd_starve fifo=%0d waited=%0d", i, waitc[i]); end
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (g[i] === 1'b1 && q[i].size() != 0) begin
                    v = q[i].pop_front();
                    n_cmp++; if (v != rd[i]) begin n_fail++; $display("FAIL rnd_order fifo=%0d got=%0d exp=%0d", i, v, rd[i]); end
                    rd[i]++;
                end
            end
            if (cyc < 1000) begin
                for (int i = 0; i < 4; i++) begin
                    if (q[i].size() < 8 && $urandom_range(0, 2) == 0) begin
                        q[i].push_back(wr[i]);
                        wr[i]++;
                    end
                end
            end
            if (!b) begin
                if (expi >= 0) begin
                    if (m_cnt > 0 && m_cnt < BR && expi == int'(m_owner)) begin
                        m_cnt++;
                    end else begin
                        m_owner = 2'(expi);
                        m_cnt   = 1;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (q[i].size() != 0 || rd[i] != wr[i]) begin
                n_fail++; $display("FAIL rnd_drain fifo=%0d left=%0d popped=%0d pushed=%0d", i, q[i].size(), rd[i], wr[i]);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst      = 1'b1;
        bus.blk  = 1'b0;
        bus.reqs = '0;
        test_reset();
        test_rotation();
        test_sole_requester();
        test_owner_drop();
        test_blk();
        test_rst_mid_burst();
        test_random_fifos();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
